// File: rtl/pe_arr_seq.sv
// pe_arr_seq: job sequencer for the PE_ARR systolic array (clear, skewed feed, drain, done); optional stall counter under PE_ARR_SEQ_STALL_CNT_EN
module pe_arr_seq #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int PE_LAT = 1,
   parameter int KW     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KW-1:0]     k_len,
   output logic              busy,
   output logic              done,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [8*COLS-1:0] w_data,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [8*ROWS-1:0] a_data,
   output logic              arr_clr,
   output logic              arr_fire,
   output logic [8*COLS-1:0] arr_in_w,
   output logic [8*ROWS-1:0] arr_in_a,
   output logic              res_valid
`ifdef PE_ARR_SEQ_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);
   localparam int DL = ROWS + COLS + PE_LAT - 1;
   localparam int DW = $clog2(DL + 1);
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
   state_t state, state_n;
   logic [KW-1:0] k_reg, bcnt;
   logic [DW-1:0] dcnt;
   logic acc, last_beat, last_drain, shift;
   assign acc        = state == FEED && w_valid && a_valid;
   assign last_beat  = acc && bcnt == k_reg - KW'(1);
   assign last_drain = dcnt == DW'(DL - 1);
   assign shift      = state == FEED || state == DRAIN;
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   // next state and state-decoded outputs
   always_comb begin
      state_n   = state;
      busy      = state == CLEAR || state == FEED || state == DRAIN;
      done      = state == DONE;
      res_valid = state == DONE;
      arr_clr   = state == CLEAR;
      arr_fire  = shift;
      w_ready   = state == FEED && a_valid;
      a_ready   = state == FEED && w_valid;
      case (state)
         IDLE:    if (start) state_n = k_len == '0 ? DONE : CLEAR;
         CLEAR:   state_n = FEED;
         FEED:    if (last_beat) state_n = DRAIN;
         DRAIN:   if (last_drain) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // job length latch plus beat and drain counters; drain counter wraps to 0 on exit
   always_ff @(posedge clk)
      if (rst) begin
         k_reg <= '0;
         bcnt  <= '0;
         dcnt  <= '0;
      end else begin
         if (state == IDLE && start) k_reg <= k_len;
         if (state == CLEAR) bcnt <= '0;
         else if (acc) bcnt <= bcnt + KW'(1);
         if (state == DRAIN) dcnt <= last_drain ? '0 : dcnt + DW'(1);
      end
   for (genvar i = 0; i < COLS; i++) begin : g_w
      logic [8*(i+1)-1:0] sr;
      // weight lane delay line of depth i+1; bubbles and drain shift in zeros
      always_ff @(posedge clk)
         if (rst || state == CLEAR) sr <= '0;
         else if (shift) sr <= (8*(i+1))'({sr, acc ? w_data[8*i +: 8] : 8'h00});
      assign arr_in_w[8*i +: 8] = sr[8*i +: 8];
   end
   for (genvar j = 0; j < ROWS; j++) begin : g_a
      logic [8*(j+1)-1:0] sr;
      // activation lane delay line of depth j+1; bubbles and drain shift in zeros
      always_ff @(posedge clk)
         if (rst || state == CLEAR) sr <= '0;
         else if (shift) sr <= (8*(j+1))'({sr, acc ? a_data[8*j +: 8] : 8'h00});
      assign arr_in_a[8*j +: 8] = sr[8*j +: 8];
   end
`ifdef PE_ARR_SEQ_STALL_CNT_EN
   // FEED cycles without an accepted beat, saturating
   always_ff @(posedge clk)
      if (rst || state == CLEAR) stall_cnt <= '0;
      else if (state == FEED && !acc && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_pe_arr_seq.sv
// tb_pe_arr_seq: table-driven job bench with cycle model and done-cycle scoreboard for pe_arr_seq
module tb_pe_arr_seq;
   localparam int ROWS = 4, COLS = 4, PE_LAT = 1, KW = 16;
   localparam int DL = ROWS + COLS + PE_LAT - 1;
   logic clk = 1'b0;
   logic rst, start, w_valid, a_valid;
   logic [KW-1:0] k_len;
   logic [8*COLS-1:0] w_data, arr_in_w;
   logic [8*ROWS-1:0] a_data, arr_in_a;
   logic busy, done, w_ready, a_ready, arr_clr, arr_fire, res_valid;
`ifdef PE_ARR_SEQ_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif
   int n_run = 0, n_fail = 0;
   int done_q[$];
   typedef struct {
      int k;
      int pat;
      int exp_done;
      int exp_stall;
      bit hold;
   } vec_t;
   vec_t vecs[6];
   logic [8*COLS-1:0] hw[0:255];
   logic [8*ROWS-1:0] ha[0:255];

   always #5 clk = ~clk;

   pe_arr_seq #(.ROWS(ROWS), .COLS(COLS), .PE_LAT(PE_LAT), .KW(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .arr_clr(arr_clr), .arr_fire(arr_fire), .arr_in_w(arr_in_w), .arr_in_a(arr_in_a),
      .res_valid(res_valid)
`ifdef PE_ARR_SEQ_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_res_valid"}, res_valid, 1'b0);
      chk({tag, "_fire"}, arr_fire, 1'b0);
      chk({tag, "_clr"}, arr_clr, 1'b0);
      chk({tag, "_w_ready"}, w_ready, 1'b0);
      chk({tag, "_a_ready"}, a_ready, 1'b0);
      chk({tag, "_in_w"}, arr_in_w, '0);
      chk({tag, "_in_a"}, arr_in_a, '0);
   endtask

   // one job from start (cycle 0) until back in IDLE, checked every cycle against the model
   task automatic run_job(input vec_t v);
      int c, n, l, stall, dcyc, endc;
      logic [8*COLS-1:0] ew;
      logic [8*ROWS-1:0] ea;
      logic fe, ac, dr, de, be;
      n = 0; l = -1; stall = 0; dcyc = -1;
      for (int t = 0; t < 256; t++) begin
         hw[t] = '0;
         ha[t] = '0;
      end
      endc = (v.k == 0) ? 2 : 249;
      if (v.k == 0) done_q.push_back(1);
      c = 0;
      while (c <= endc && c < 250) begin
         start   = (c == 0) || v.hold;
         k_len   = (c == 0) ? KW'(v.k) : KW'($urandom);
         w_data  = $urandom;
         a_data  = $urandom;
         w_valid = (v.pat == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         a_valid = (v.pat == 0) ? 1'b1 : (v.pat == 1) ? c[0] : 1'($urandom_range(0, 1));
         #1;
         fe = v.k != 0 && c >= 2 && l < 0;
         ac = fe && w_valid && a_valid;
         if (ac) begin
            hw[c] = w_data;
            ha[c] = a_data;
            n++;
            if (n == v.k) begin
               l = c;
               endc = l + DL + 2;
               done_q.push_back(l + DL + 1);
            end
         end
         if (fe && !ac) stall++;
         dr = l >= 0 && c > l && c <= l + DL;
         de = (v.k == 0) ? (c == 1) : (l >= 0 && c == l + DL + 1);
         be = v.k != 0 && (c == 1 || fe || dr);
         for (int i = 0; i < COLS; i++) ew[8*i +: 8] = (c - 1 - i >= 0) ? hw[c-1-i][8*i +: 8] : 8'h00;
         for (int j = 0; j < ROWS; j++) ea[8*j +: 8] = (c - 1 - j >= 0) ? ha[c-1-j][8*j +: 8] : 8'h00;
         chk("busy", busy, be);
         chk("done", done, de);
         chk("res_valid", res_valid, de);
         chk("arr_clr", arr_clr, v.k != 0 && c == 1);
         chk("arr_fire", arr_fire, fe || dr);
         chk("w_ready", w_ready, fe && a_valid);
         chk("a_ready", a_ready, fe && w_valid);
         chk("arr_in_w", arr_in_w, ew);
         chk("arr_in_a", arr_in_a, ea);
         if (done) begin
            dcyc = c;
            if (done_q.size() == 0) chk("done_unexpected", 1'b1, 1'b0);
            else chk("done_cycle", c, done_q.pop_front());
         end
         step();
         c++;
      end
      if (c >= 250) chk("job_timeout", 1'b1, 1'b0);
      chk("done_missing", done_q.size(), 0);
      done_q.delete();
      if (v.exp_done >= 0) chk("done_table", dcyc, v.exp_done);
`ifdef PE_ARR_SEQ_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, (v.exp_stall >= 0) ? v.exp_stall : stall);
`endif
      if (v.hold) begin
         chk("hold_restart_clr", arr_clr, 1'b1);
         chk("hold_restart_busy", busy, 1'b1);
      end
      start = 1'b0;
   endtask

   initial begin
      vecs[0] = '{3, 0, 13, 0, 1'b0};
      vecs[1] = '{4, 1, 18, 4, 1'b0};
      vecs[2] = '{0, 0, 1, 0, 1'b0};
      vecs[3] = '{1, 0, 11, 0, 1'b0};
      vecs[4] = '{6, 2, -1, -1, 1'b0};
      vecs[5] = '{2, 0, 12, 0, 1'b1};
      rst = 1'b1; start = 1'b0; k_len = '0;
      w_valid = 1'b0; a_valid = 1'b0; w_data = '0; a_data = '0;
      // reset with random inputs
      for (int r = 0; r < 2; r++) begin
         start   = 1'($urandom_range(0, 1));
         k_len   = KW'($urandom);
         w_valid = 1'($urandom_range(0, 1));
         a_valid = 1'($urandom_range(0, 1));
         w_data  = $urandom;
         a_data  = $urandom;
         step();
         chk_idle_outputs("reset");
      end
      rst = 1'b0; start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
      step();
      for (int t = 0; t < 6; t++) run_job(vecs[t]);
      // abort a k_len=5 job with reset in its second FEED cycle
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      start = 1'b1; k_len = KW'(5); w_valid = 1'b1; a_valid = 1'b1;
      step();
      start = 1'b0;
      chk("abort_clr", arr_clr, 1'b1);
      step();
      step();
      chk("abort_feed_ready", w_ready, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle_outputs("abort");
      step();
      chk_idle_outputs("abort_after");
      w_valid = 1'b0; a_valid = 1'b0;
      run_job('{2, 0, 12, 0, 1'b0});
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/pe_arr_seq.md
Name: pe_arr_seq

Overview:
- Sequencer for the PE_ARR systolic array.
- Accepts a job of K weight/activation vector pairs from upstream valid/ready streams.
- Clears the array accumulators, applies diagonal skew to both input buses, drives fire, counts drain cycles, then flags that the array outputs are final.
- Sits between the operand buffers and PE_ARR; the array outputs go straight to the consumer, qualified by res_valid.

Parameters:
ROWS, 4, array rows; activation lanes
COLS, 4, array columns; weight lanes
PE_LAT, 1, per-PE MAC register latency in cycles
KW, 16, width of job length field

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  job start request, sampled in IDLE only
k_len  in  KW  vector pairs in job, latched on accepted start
busy  out  1  high in CLEAR/FEED/DRAIN
done  out  1  one-cycle pulse at job end
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat ready
w_data  in  8*COLS  weight beat, lane i = bits [8i +: 8]
a_valid  in  1  activation beat valid
a_ready  out  1  activation beat ready
a_data  in  8*ROWS  activation beat, lane j = bits [8j +: 8]
arr_clr  out  1  accumulator clear pulse to array
arr_fire  out  1  array enable (PE_ARR fire)
arr_in_w  out  8*COLS  skewed weights to array
arr_in_a  out  8*ROWS  skewed activations to array
res_valid  out  1  array outputs final; coincident with done

Behaviour:
- Reset: all outputs 0; state IDLE; skew registers, beat counter and drain counter 0. Reset mid-job aborts with no done pulse. The next start after reset is accepted normally.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - start=1 with k_len!=0: latch k_len, go to CLEAR.
  - start=1 with k_len==0: go to DONE directly; no arr_clr, no fire.
- CLEAR: arr_clr=1 for exactly one cycle; skew registers zeroed; go to FEED.
- FEED:
  - arr_fire=1.
  - w_ready = a_valid; a_ready = w_valid. The two streams are consumed jointly; a beat is accepted when w_valid&&a_valid.
  - Each FEED cycle the skew pipe shifts. It loads the accepted beat, or an all-zero bubble if no beat is accepted.
  - After the k_len-th accepted beat, go to DRAIN on the next cycle.
- Skew:
  - Weight lane i is delayed i+1 cycles from acceptance; activation lane j is delayed j+1 cycles.
  - Lane 0 of a beat accepted in cycle t appears on arr_in_* in cycle t+1.
  - Outputs are registered.
- DRAIN:
  - arr_fire=1; zeros are shifted in.
  - Lasts exactly ROWS+COLS+PE_LAT-1 cycles (counter wraps to 0 at exit); then go to DONE.
- DONE: done=1, res_valid=1, arr_fire=0 for one cycle; then IDLE.
- Ready signals are 0 outside FEED.
- start is ignored while busy or in DONE.
- Beat counter is KW bits; k_len = 2^KW-1 is legal and has no overflow.

Optional Feature:
- Macro: PE_ARR_SEQ_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], counting FEED cycles in which no beat is accepted.
  - Cleared in CLEAR and on rst; saturates at 0xFFFFFFFF; holds its value after DONE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> busy, done, arr_fire, arr_clr, readies all 0; arr_in_w=arr_in_a=0.
- Job ROWS=COLS=4, k_len=3, both valids held high, start in cycle 0:
  - arr_clr in cycle 1.
  - Accepts in cycles 2-4.
  - Beat0 w lane0 on arr_in_w in cycle 3, lane3 in cycle 6.
  - DRAIN in cycles 5-12.
  - done=res_valid=1 in cycle 13 only.
- Backpressure, k_len=4, a_valid low on alternate FEED cycles:
  - w_ready low in exactly those cycles.
  - Zero lanes injected for bubbles.
  - FEED in cycles 2-9, done in cycle 18.
  - With the macro defined, stall_cnt=4.
- k_len=0, start in cycle 0 -> done in cycle 1; arr_clr and arr_fire never asserted.
- rst pulsed in second FEED cycle of a k_len=5 job -> next cycle IDLE, readies 0, buses 0, no done. A fresh k_len=2 job then completes with done at cycle 12 relative to its start.
- start held high during a whole job -> exactly one done per job; a new job begins only after the return to IDLE.
